// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the handshaked execute-stage ALU.
//   aluop_e          : 4-bit R-type / M-extension operation code
//   ALU_OP_W         : width of the operation code
//   alu_seq_state_e  : control FSM state encoding
//   is_mext()        : true for the multiply/divide codes (1010..1111)
//   is_divrem()      : true for the divide/remainder codes (1100..1111)
//   is_rem()         : true for REM/REMU
// ---------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001,
      ALU_MUL  = 4'b1010,
      ALU_MULH = 4'b1011,
      ALU_DIV  = 4'b1100,
      ALU_DIVU = 4'b1101,
      ALU_REM  = 4'b1110,
      ALU_REMU = 4'b1111
   } aluop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } alu_seq_state_e;

   function automatic logic is_mext(aluop_e op);
      return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic is_divrem(aluop_e op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic is_rem(aluop_e op);
      return op inside {ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Operation/result handshake bundle for alu_seq.
//   in_valid/in_ready   : operation transfer (aluop, opr_a, opr_b)
//   out_valid/out_ready : result transfer (opr_res)
//   busy                : iterative multiply/divide engine occupied
// Modports: master = pipeline side issuing ops, slave = the ALU.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int XLEN = 32
);
   import alu_seq_pkg::*;

   logic            in_valid;
   logic            in_ready;
   aluop_e          aluop;
   logic [XLEN-1:0] opr_a;
   logic [XLEN-1:0] opr_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] opr_res;
   logic            busy;

   modport master (
      output in_valid, aluop, opr_a, opr_b, out_ready,
      input  in_ready, out_valid, opr_res, busy
   );

   modport slave (
      input  in_valid, aluop, opr_a, opr_b, out_ready,
      output in_ready, out_valid, opr_res, busy
   );

endinterface

// File: rtl/alu_seq_muldiv.sv
// ---------------------------------------------------------------------------
// alu_seq_muldiv
// Iterative RV32M engine: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, XLEN cycles per operation. Signed ops run on operand
// magnitudes and the result is negated on the way out.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (ignored for special cases upstream)
//   op         : operation code, captured on start
//   a, b       : operands, captured on start
//   done       : high during the final iteration cycle
//   res        : sign-corrected result, valid once the iterations completed
// Only instantiated when ALU_SEQ_MEXT_EN is defined.
// ---------------------------------------------------------------------------
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  aluop_e          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] res
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

   // acc holds {product high, multiplier/product low} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   operand;
   logic [SHW-1:0]    count;
   logic              active;
   logic              neg_res;
   aluop_e            op_q;

   logic              signed_op;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              neg_load;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_cand;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] step_acc;

   logic [2*XLEN-1:0] acc_fix;
   logic [XLEN-1:0]   rem_fix;

   // Operand conditioning at start: magnitudes for signed ops and the sign
   // the final result must carry (quotient/product: XOR, remainder: dividend).
   always_comb begin
      signed_op = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
      a_neg     = signed_op && a[XLEN-1];
      b_neg     = signed_op && b[XLEN-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      neg_load  = 1'b0;
      if ((op == ALU_MULH) || (op == ALU_DIV)) begin
         neg_load = a_neg ^ b_neg;
      end else if (op == ALU_REM) begin
         neg_load = a_neg;
      end
   end

   // One iteration of either algorithm. Restoring divide shifts the next
   // dividend bit into the remainder and subtracts the divisor when it fits;
   // the difference always fits XLEN bits because remainder < divisor.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      div_cand = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff = div_cand[XLEN-1:0] - operand;
      step_acc = {mul_sum, acc[XLEN-1:1]};
      if (is_divrem(op_q)) begin
         if (div_cand >= {1'b0, operand}) begin
            step_acc = {div_diff, acc[XLEN-2:0], 1'b1};
         end else begin
            step_acc = {div_cand[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end
   end

   // Engine registers: load on start, then iterate XLEN times.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         operand <= '0;
         count   <= '0;
         active  <= 1'b0;
         neg_res <= 1'b0;
         op_q    <= ALU_MUL;
      end else if (start) begin
         acc     <= {{XLEN{1'b0}}, a_mag};
         operand <= b_mag;
         count   <= '0;
         active  <= 1'b1;
         neg_res <= neg_load;
         op_q    <= op;
      end else if (active) begin
         acc   <= step_acc;
         count <= count + 1'b1;
         if (count == LAST_STEP) begin
            active <= 1'b0;
         end
      end
   end

   assign done = active && (count == LAST_STEP);

   // Sign fix-up. The low half of the negated 2*XLEN value equals the
   // negated quotient, so one negator serves MULH and DIV; the remainder
   // needs its own XLEN-bit negation.
   always_comb begin
      acc_fix = neg_res ? -acc : acc;
      rem_fix = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         ALU_MULH:          res = acc_fix[2*XLEN-1:XLEN];
         ALU_REM, ALU_REMU: res = rem_fix;
         default:           res = acc_fix[XLEN-1:0];
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked execute-stage ALU. Base RV32I R-type ops complete in one cycle
// into a registered result slot; with ALU_SEQ_MEXT_EN defined, RV32M ops run
// on the iterative alu_seq_muldiv engine (XLEN+1 cycles) while divide-by-zero
// and signed-overflow cases resolve in one cycle. Without the macro the
// M-ext codes return 0 in one cycle and busy is tied low.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if slave (in_valid/in_ready, aluop, opr_a, opr_b,
//           out_valid/out_ready, opr_res, busy); XLEN must match the
//           interface instance.
// ---------------------------------------------------------------------------
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);

   localparam int SHW = $clog2(XLEN);

   logic            out_valid_q;
   logic [XLEN-1:0] res_q;
   logic            out_free;
   logic            in_ready_int;
   logic            accept;
   logic            direct;
   logic [XLEN-1:0] direct_res;
   logic            eng_write;
   logic [XLEN-1:0] eng_res;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] base_res;

   // The result slot can take new data when empty or being drained now;
   // this is what allows one base op per cycle under full throughput.
   assign out_free = !out_valid_q || bus.out_ready;
   assign shamt    = bus.opr_b[SHW-1:0];

   // Single-cycle RV32I R-type datapath; M-ext codes fall through to 0.
   always_comb begin
      case (bus.aluop)
         ALU_ADD:  base_res = bus.opr_a + bus.opr_b;
         ALU_SUB:  base_res = bus.opr_a - bus.opr_b;
         ALU_SLL:  base_res = bus.opr_a << shamt;
         ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.opr_a) < $signed(bus.opr_b))};
         ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.opr_a < bus.opr_b)};
         ALU_XOR:  base_res = bus.opr_a ^ bus.opr_b;
         ALU_SRL:  base_res = bus.opr_a >> shamt;
         ALU_SRA:  base_res = $unsigned($signed(bus.opr_a) >>> shamt);
         ALU_OR:   base_res = bus.opr_a | bus.opr_b;
         ALU_AND:  base_res = bus.opr_a & bus.opr_b;
         default:  base_res = '0;
      endcase
   end

`ifdef ALU_SEQ_MEXT_EN

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_MUL  = ST_MUL;
   localparam logic [1:0] S_DIV  = ST_DIV;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0] state;
   logic       div_zero;
   logic       div_ovf;
   logic       start_eng;
   logic       eng_done;

   // Divide special cases never enter the engine; they take the 1-cycle path.
   assign div_zero = is_divrem(bus.aluop) && (bus.opr_b == '0);
   assign div_ovf  = ((bus.aluop == ALU_DIV) || (bus.aluop == ALU_REM))
                     && (bus.opr_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.opr_b == '1);

   always_comb begin
      direct_res = base_res;
      if (div_zero) begin
         direct_res = is_rem(bus.aluop) ? bus.opr_a : '1;
      end else if (div_ovf) begin
         direct_res = (bus.aluop == ALU_REM) ? '0 : bus.opr_a;
      end
   end

   assign direct       = !is_mext(bus.aluop) || div_zero || div_ovf;
   assign in_ready_int = (state == S_IDLE) && out_free;
   assign accept       = bus.in_valid && in_ready_int;
   assign start_eng    = accept && !direct;
   assign eng_write    = (state == S_DONE) && out_free;

   // Control FSM: launch the engine, wait out its iterations, then hold in
   // DONE until the result slot is free so no engine result is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_eng) begin
                  state <= is_divrem(bus.aluop) ? S_DIV : S_MUL;
               end
            end
            S_MUL, S_DIV: begin
               if (eng_done) begin
                  state <= S_DONE;
               end
            end
            default: begin
               if (out_free) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   alu_seq_muldiv #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_eng),
      .op    (bus.aluop),
      .a     (bus.opr_a),
      .b     (bus.opr_b),
      .done  (eng_done),
      .res   (eng_res)
   );

   assign bus.busy = (state != S_IDLE);

`else

   assign direct_res   = base_res;
   assign direct       = 1'b1;
   assign in_ready_int = out_free;
   assign accept       = bus.in_valid && in_ready_int;
   assign eng_write    = 1'b0;
   assign eng_res      = '0;
   assign bus.busy     = 1'b0;

`endif

   // Result slot: filled by a 1-cycle op at acceptance or by the engine in
   // DONE, emptied when the consumer takes it without a refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
      end else if (accept && direct) begin
         out_valid_q <= 1'b1;
         res_q       <= direct_res;
      end else if (eng_write) begin
         out_valid_q <= 1'b1;
         res_q       <= eng_res;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_q;
   assign bus.opr_res   = res_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at XLEN=32. A reference model computes
// each accepted op's result from the ISA rules; a monitor compares every
// drained result against an in-order scoreboard and checks that a stalled
// result stays put. Directed cases add hand-computed results and latencies.
// Honours ALU_SEQ_MEXT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int XLEN = 32;
`ifdef ALU_SEQ_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif
   localparam int ITER_LAT = MEXT ? XLEN + 1 : 0;

   logic clk = 1'b0;
   logic rst_n;

   alu_seq_if #(.XLEN(XLEN)) bus ();

   alu_seq #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int              errors    = 0;
   int              checks    = 0;
   int              pop_count = 0;
   logic [XLEN-1:0] sb[$];
   logic            hold_valid = 1'b0;
   logic [XLEN-1:0] hold_res;

   // Reference model: results straight from the RV32I/RV32M definitions.
   function automatic logic [31:0] model(aluop_e op, logic [31:0] a, logic [31:0] b);
      longint     sa;
      longint     sbv;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (!MEXT && is_mext(op)) return 32'h0;
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'b0, ($signed(a) < $signed(b))};
         ALU_SLTU: return {31'b0, (a < b)};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         ALU_MUL:  begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         ALU_MULH: begin p = 64'(sa * sbv); return p[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(sa / sbv);
         end
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return 32'(sa % sbv);
         end
         ALU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
         default:  return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Present one op and hold it until accepted; its model result joins the
   // scoreboard. Returns just after the accepting edge.
   task automatic applyStimulus(input aluop_e op, input logic [31:0] a, input logic [31:0] b);
      int waited = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.aluop    = op;
      bus.opr_a    = a;
      bus.opr_b    = b;
      #1;
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept timeout: in_ready=%0b, expected 1", bus.in_ready);
         bus.in_valid = 1'b0;
      end else begin
         sb.push_back(model(op, a, b));
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   // One op in isolation: hand-computed result and edge-count latency.
   task automatic runOne(input string name, input aluop_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int   off     = 0;
      logic busy_ok = 1'b1;
      bus.out_ready = 1'b1;
      checkOutput({name, " model"}, model(op, a, b), exp_res);
      applyStimulus(op, a, b);
      while (!bus.out_valid && off < 200) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         off++;
      end
      checkOutput({name, " result"}, bus.opr_res, exp_res);
      checkOutput({name, " latency"}, 32'(off), 32'(exp_lat));
      if (exp_lat > 0) checkOutput({name, " busy"}, {31'b0, busy_ok && !bus.busy}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name);
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      checkOutput({name, " drained"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: in-order result checking and stall stability.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n !== 1'b1) begin
            hold_valid = 1'b0;
         end else if (bus.out_valid) begin
            if (hold_valid) checkOutput("stall stability", bus.opr_res, hold_res);
            if (bus.out_ready) begin
               hold_valid = 1'b0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected result: got 0x%08h, expected none", bus.opr_res);
               end else begin
                  checkOutput("scoreboard", bus.opr_res, sb.pop_front());
                  pop_count++;
               end
            end else begin
               hold_res   = bus.opr_res;
               hold_valid = 1'b1;
            end
         end else begin
            hold_valid = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exceeded");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int c;
      int idx;
      int pop_before;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.aluop     = ALU_ADD;
      bus.opr_a     = '0;
      bus.opr_b     = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
      checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset opr_res", bus.opr_res, 32'd0);
      checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOne("ADD wrap", ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0);
      runOne("SUB", ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0);
      runOne("XOR", ALU_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 0);
      runOne("SRA", ALU_SRA, 32'h80000000, 32'h00000021, 32'hC0000000, 0);
      runOne("SLT", ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0);
      runOne("SLTU", ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
      runOne("SLL", ALU_SLL, 32'h00000003, 32'h0000003F, 32'h80000000, 0);

      runOne("MUL", ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, MEXT ? 32'h00000001 : 32'h0, ITER_LAT);
      runOne("MULH", ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ITER_LAT);
      runOne("DIV", ALU_DIV, 32'hFFFFFFF9, 32'h00000002, MEXT ? 32'hFFFFFFFD : 32'h0, ITER_LAT);
      runOne("REM", ALU_REM, 32'hFFFFFFF9, 32'h00000002, MEXT ? 32'hFFFFFFFF : 32'h0, ITER_LAT);
      runOne("DIVU by 0", ALU_DIVU, 32'h00000007, 32'h00000000, MEXT ? 32'hFFFFFFFF : 32'h0, 0);
      runOne("REMU by 0", ALU_REMU, 32'h00000007, 32'h00000000, MEXT ? 32'h00000007 : 32'h0, 0);
      runOne("DIV ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, MEXT ? 32'h80000000 : 32'h0, 0);
      runOne("REM ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

      // Five back-to-back ADDs with the consumer stalled for cycles 2..4.
      pop_before = pop_count;
      idx = 0;
      c   = 0;
      while (idx < 5 && c < 50) begin
         @(negedge clk);
         bus.out_ready = !(c >= 2 && c <= 4);
         bus.in_valid  = 1'b1;
         bus.aluop     = ALU_ADD;
         bus.opr_a     = 32'h00000100 * (idx + 1);
         bus.opr_b     = 32'(idx + 7);
         #1;
         if (c >= 2 && c <= 4) checkOutput("stall in_ready", {31'b0, bus.in_ready}, 32'd0);
         if (bus.in_ready) begin
            sb.push_back(model(ALU_ADD, bus.opr_a, bus.opr_b));
            idx++;
         end
         c++;
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      waitDrain("backpressure");
      checkOutput("backpressure count", 32'(pop_count - pop_before), 32'd5);

      // Mixed vectors against the model, issued back to back.
      bus.out_ready = 1'b1;
      applyStimulus(ALU_SRL, 32'h80000000, 32'h00000024);
      applyStimulus(ALU_OR, 32'h12340000, 32'h00005678);
      applyStimulus(ALU_AND, 32'hFF00FF00, 32'h0FF00FF0);
      applyStimulus(ALU_SLT, 32'h80000000, 32'h7FFFFFFF);
      applyStimulus(ALU_MUL, 32'h00000007, 32'h00000006);
      applyStimulus(ALU_MULH, 32'h80000000, 32'h80000000);
      applyStimulus(ALU_MULH, 32'hFFFFFFFD, 32'h00000005);
      applyStimulus(ALU_DIV, 32'h00000064, 32'hFFFFFFF9);
      applyStimulus(ALU_REM, 32'hFFFFFF9C, 32'h00000007);
      applyStimulus(ALU_DIVU, 32'hFFFFFFFF, 32'h00000010);
      applyStimulus(ALU_REMU, 32'hFFFFFFFF, 32'h00000007);
      applyStimulus(ALU_DIV, 32'h00000007, 32'h00000000);
      applyStimulus(ALU_ADD, 32'hDEADBEEF, 32'h11111111);
      waitDrain("mixed");

      // Reset in the middle of a divide.
      bus.out_ready = 1'b1;
      applyStimulus(ALU_DIV, 32'hFFFFFFF9, 32'h00000002);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-op reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("mid-op reset busy", {31'b0, bus.busy}, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
      runOne("ADD after reset", ALU_ADD, 32'h00000005, 32'h00000006, 32'h0000000B, 0);

      repeat (3) @(posedge clk);
      checkOutput("final scoreboard", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle R-type ALU in the execute stage. It accepts one operation per `in_valid`/`in_ready` transfer and registers the result behind an `out_valid`/`out_ready` interface. It implements the complete RV32I R-type operation set at 1-cycle latency. When compiled in, it adds RV32M multiply/divide through an iterative engine, which lets the pipeline stall on long-latency execute ops.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived, not overridden).

Ports:
- `clk`: input, 1 bit. Single clock; all state on rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Operation present.
- `in_ready`: output, 1 bit. Block can accept; a transfer occurs when `in_valid & in_ready` is high at a rising edge.
- `aluop`: input, 4 bits. Operation code (`aluop_e`).
- `opr_a`: input, `XLEN` bits. Operand A / rs1.
- `opr_b`: input, `XLEN` bits. Operand B / rs2.
- `out_valid`: output, 1 bit. Result register holds a result.
- `out_ready`: input, 1 bit. Consumer takes the result; a transfer occurs when `out_valid & out_ready` is high at a rising edge.
- `opr_res`: output, `XLEN` bits. Result; stable while `out_valid & !out_ready`.
- `busy`: output, 1 bit. Iterative engine occupied.

## Operation
Opcode encoding (unique, no aliases):

| Code | Op | Code | Op |
|---|---|---|---|
| 0000 | ADD | 1000 | OR |
| 0001 | SUB | 1001 | AND |
| 0010 | SLL | 1010 | MUL |
| 0011 | SLT | 1011 | MULH |
| 0100 | SLTU | 1100 | DIV |
| 0101 | XOR | 1101 | DIVU |
| 0110 | SRL | 1110 | REM |
| 0111 | SRA | 1111 | REMU |

Base-op rules:
- ADD/SUB wrap modulo 2^XLEN.
- Shifts use `opr_b[SHW-1:0]` only; SRA sign-fills.
- SLT compares signed, SLTU compares unsigned; result is zero-extended 0/1.

M-op rules:
- MUL returns the low XLEN bits of the product.
- MULH returns the high XLEN bits of the signed×signed product.
- DIV/REM are signed, truncating toward zero; the remainder takes the sign of the dividend.
- Signed M-ops work on magnitudes, then conditionally negate the result.

M-op special cases. These are resolved at acceptance with 1-cycle latency and do not start the engine:
- Divide by zero: DIV/DIVU return all ones; REM/REMU return `opr_a`.
- Signed overflow (DIV of most-negative by −1): DIV returns `opr_a`; REM returns 0.

FSM states:
- `IDLE`: base ops and special cases load the result register directly. Other M-ops load the engine and go to `MUL` or `DIV`.
- `MUL`: radix-2 shift-add, one bit per cycle, XLEN cycles.
- `DIV`: restoring division, one quotient bit per cycle, XLEN cycles.
- `DONE`: one cycle for sign fix-up, then the result register is written and the FSM returns to `IDLE`.

Handshake rules:
- `in_ready = (state==IDLE) & (!out_valid | out_ready)`. A full, unconsumed result register blocks acceptance.
- `busy` is high in `MUL`, `DIV` and `DONE`.
- An M-op whose result cannot be written in `DONE` (`out_valid & !out_ready`) holds `DONE` until space frees.
- Simultaneous output drain and new acceptance in the same cycle is legal: full throughput for base ops.

Reset:
- `in_ready` = 1, `out_valid` = 0, `opr_res` = 0, `busy` = 0, FSM = `IDLE`.
- Asserting reset mid-operation discards the in-flight op with no partial output.

## Timing
- Base ops and special cases: accepted at edge E, `out_valid` high after E; 1 result/cycle sustained with `out_ready` held high.
- Iterative M-ops:
  - Accepted at edge E.
  - `busy` high after E.
  - `out_valid` high after edge E+XLEN+1 (33 cycles at XLEN=32).
  - `busy` low in the same cycle `out_valid` rises.
- Outputs are registered; no combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_SEQ_MEXT_EN` defined: M-ops behave as above; `alu_seq_muldiv` is instantiated.
- Not defined:
  - Codes 1010–1111 return 0 with base-op latency.
  - `busy` is tied 0; no engine logic.
  - FSM reduces to `IDLE`.

## Structure
- `alu_seq_pkg` holds:
  - `aluop_e` enum (4 bits).
  - `ALU_OP_W` = 4.
  - The FSM state enum `alu_seq_state_e`.
  - Helper function `is_mext(aluop_e)`.
- Sub-module `alu_seq_muldiv`: iterative engine (multiplicand/product and divisor/remainder registers, bit counter, sign flags) with start/done ports. It is instantiated only under `ALU_SEQ_MEXT_EN`.

## Test plan
Directed scenarios at XLEN=32:
- Basic arithmetic: ADD 0x7FFFFFFF+1 → 0x80000000, 1 cycle; SUB 0−1 → 0xFFFFFFFF; XOR 0xF0F0F0F0^0xFFFFFFFF → 0x0F0F0F0F.
- Shifts and compares: SRA 0x80000000 by `opr_b`=0x21 → 0xC0000000 (shamt 1); SLT 0xFFFFFFFF,1 → 1; SLTU 0xFFFFFFFF,1 → 0.
- Output backpressure: 5 back-to-back ADDs with `out_ready` low for cycles 2–4 → `in_ready` low during the stall, results in order, none lost or duplicated, `opr_res` stable while stalled.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 and MULH same operands → 0x00000000. Each arrives exactly 33 cycles after acceptance with `busy` high throughout.
- Divide and special cases: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7 (1 cycle); DIV 0x80000000/0xFFFFFFFF → 0x80000000 (1 cycle).
- Reset mid-operation: `rst_n` low at cycle 10 of a DIV → `out_valid` and `busy` 0 immediately, `in_ready` 1 after release, next ADD correct.
